act_lut_scheduler: RTL and testbench



---
 rtl/act_pkg.sv | 42 ++++
 rtl/act_interp_pipe.sv | 72 +++++++
 rtl/act_lut_scheduler.sv | 122 ++++++++++++
 tb/tb_act_lut_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// ============================================================================
// Package  : act_pkg
// Brief    : Shared widths, FSM encoding and the LUT interpolation function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_pkg;

    localparam int c_DW = 8;
    localparam int c_AW = 4;
    localparam int c_FW = c_DW - c_AW;
    localparam int c_PW = c_DW + c_FW + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic signed [c_DW-1:0] fix_t;

    // base + floor((next-base)*rem / 2^FW); the result lies between base and next
    function automatic fix_t interpolate(input fix_t base, input fix_t nxt,
                                         input logic [c_FW-1:0] rem);
        logic signed [c_DW:0]   diff;
        logic signed [c_PW-1:0] prod;
        logic signed [c_PW-1:0] shifted;
        logic signed [c_PW-1:0] base_x;
        logic signed [c_PW-1:0] sum;
        diff    = {nxt[c_DW-1], nxt} - {base[c_DW-1], base};
        prod    = {{(c_PW-c_DW-1){diff[c_DW]}}, diff} * {{(c_PW-c_FW){1'b0}}, rem};
        shifted = prod >>> c_FW;
        base_x  = {{(c_PW-c_DW){base[c_DW-1]}}, base};
        sum     = base_x + shifted;
        return sum[c_DW-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_interp_pipe.sv
// ============================================================================
// Module   : act_interp_pipe
// Brief    : Table-read stage register followed by the interpolation stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_interp_pipe
    import act_pkg::*;
#(
    parameter int DW = c_DW,
    parameter int AW = c_AW,
    parameter int IW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [IW-1:0]        i_idx,
    input  logic [DW-1:0]        i_z,
    input  logic [(DW<<AW)-1:0]  i_table,
    output logic                 o_valid,
    output logic [IW-1:0]        o_idx,
    output logic [DW-1:0]        o_a
);

    localparam int c_RW = DW - AW;

    logic [AW-1:0]   w_addr;
    logic [AW-1:0]   w_addr_nx;
    logic            r_s1_valid_q, w_s1_valid_d;
    logic [IW-1:0]   r_s1_idx_q,   w_s1_idx_d;
    logic [DW-1:0]   r_s1_base_q,  w_s1_base_d;
    logic [DW-1:0]   r_s1_next_q,  w_s1_next_d;
    logic [c_RW-1:0] r_s1_rem_q,   w_s1_rem_d;

    // The top entry has no successor, so it interpolates against itself
    always_comb begin
        w_addr       = i_z[DW-1:c_RW];
        w_addr_nx    = (w_addr == {AW{1'b1}}) ? w_addr : w_addr + 1'b1;
        w_s1_valid_d = i_valid;
        w_s1_idx_d   = i_idx;
        w_s1_base_d  = i_table[int'(w_addr)*DW +: DW];
        w_s1_next_d  = i_table[int'(w_addr_nx)*DW +: DW];
        w_s1_rem_d   = i_z[c_RW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid_q <= 1'b0;
            r_s1_idx_q   <= '0;
            r_s1_base_q  <= '0;
            r_s1_next_q  <= '0;
            r_s1_rem_q   <= '0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_idx_q   <= w_s1_idx_d;
            r_s1_base_q  <= w_s1_base_d;
            r_s1_next_q  <= w_s1_next_d;
            r_s1_rem_q   <= w_s1_rem_d;
        end
    end

    // Stage-2 result is registered by the owner of the result vector
    always_comb begin
        o_valid = r_s1_valid_q;
        o_idx   = r_s1_idx_q;
        o_a     = interpolate(r_s1_base_q, r_s1_next_q, r_s1_rem_q);
    end

endmodule

`default_nettype wire

// File: rtl/act_lut_scheduler.sv
// ============================================================================
// Module   : act_lut_scheduler
// Brief    : Shares one LUT + interpolation unit across the N z's of a layer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_lut_scheduler
    import act_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = c_DW,
    parameter int AW = c_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_a,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    output logic            busy
);

    localparam int              c_IW   = (N > 1) ? $clog2(N) : 1;
    localparam int              c_ZW   = N * DW;
    localparam int              c_TW   = DW << AW;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

    state_t          r_state_q, w_state_d;
    logic [c_IW-1:0] r_idx_q,   w_idx_d;
    logic [c_ZW-1:0] r_z_q,     w_z_d;
    logic [c_ZW-1:0] r_out_a_q, w_out_a_d;
    logic [c_TW-1:0] r_tbl_q,   w_tbl_d;
    logic            w_idle;
    logic            w_issue;
    logic            w_p_valid;
    logic [c_IW-1:0] w_p_idx;
    logic [DW-1:0]   w_p_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:  if (in_valid)            w_state_d = ST_RUN;
            ST_RUN:   if (r_idx_q == c_LAST)   w_state_d = ST_DRAIN;
            ST_DRAIN:                          w_state_d = ST_DONE;
            ST_DONE:  if (out_ready)           w_state_d = ST_IDLE;
            default:                           w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle    = (r_state_q == ST_IDLE);
        w_issue   = (r_state_q == ST_RUN);
        in_ready  = w_idle;
        busy      = !w_idle;
        out_valid = (r_state_q == ST_DONE);
    end

    // Table writes land only in IDLE, so a vector accepted in the same cycle
    // already reads the new entry once RUN begins.
    always_comb begin
        w_idx_d   = r_idx_q;
        w_z_d     = r_z_q;
        w_tbl_d   = r_tbl_q;
        w_out_a_d = r_out_a_q;
        if (w_idle) begin
            w_idx_d = '0;
            if (in_valid) w_z_d = in_z;
            if (cfg_we)   w_tbl_d[int'(cfg_addr)*DW +: DW] = cfg_data;
        end
        if (w_issue)   w_idx_d = r_idx_q + 1'b1;
        if (w_p_valid) w_out_a_d[int'(w_p_idx)*DW +: DW] = w_p_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_q   <= '0;
            r_z_q     <= '0;
            r_tbl_q   <= '0;
            r_out_a_q <= '0;
        end else begin
            r_idx_q   <= w_idx_d;
            r_z_q     <= w_z_d;
            r_tbl_q   <= w_tbl_d;
            r_out_a_q <= w_out_a_d;
        end
    end

    act_interp_pipe #(
        .DW (DW),
        .AW (AW),
        .IW (c_IW)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_issue),
        .i_idx   (r_idx_q),
        .i_z     (r_z_q[int'(r_idx_q)*DW +: DW]),
        .i_table (r_tbl_q),
        .o_valid (w_p_valid),
        .o_idx   (w_p_idx),
        .o_a     (w_p_a)
    );

    assign out_a = r_out_a_q;

endmodule

`default_nettype wire

// File: tb/tb_act_lut_scheduler.sv
// ============================================================================
// Module   : tb_act_lut_scheduler
// Brief    : Scoreboard bench for act_lut_scheduler with directed and random z.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_act_lut_scheduler;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int ZW = N * DW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          cfg_we    = 1'b0;
    logic [ZW-1:0] in_z      = '0;
    logic [AW-1:0] cfg_addr  = '0;
    logic [DW-1:0] cfg_data  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [ZW-1:0] out_a;

    act_lut_scheduler #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_vec   = 0;
    int            n_mis   = 0;
    int            cyc     = 0;
    int            hs_cyc  = 0;
    logic          ov_prev = 1'b0;
    logic [DW-1:0] m_tbl [1<<AW];
    logic [ZW-1:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_elem(input logic [DW-1:0] z);
        int addr, rem, base, nxt;
        addr = int'(z[DW-1:DW-AW]);
        rem  = int'(z[DW-AW-1:0]);
        base = int'($signed(m_tbl[addr]));
        nxt  = (addr == (1 << AW) - 1) ? base : int'($signed(m_tbl[addr + 1]));
        return DW'(base + (((nxt - base) * rem) >>> (DW - AW)));
    endfunction

    function automatic logic [ZW-1:0] model_vec(input logic [ZW-1:0] z);
        logic [ZW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = model_elem(z[i*DW +: DW]);
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < (1 << AW); k++) m_tbl[k] = '0;
    endtask

    // Monitor: inputs change only just after posedge, so negedge values are
    // what the next edge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_we && in_ready) m_tbl[cfg_addr] = cfg_data;
            if (in_valid && in_ready) begin
                sb.push_back(model_vec(in_z));
                hs_cyc = cyc + 1;
            end
            if (out_valid && !ov_prev) check_eq("latency", 64'(cyc - hs_cyc), 64'(N + 1));
            if (out_valid && out_ready) begin
                check_eq("sb_pop", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check_eq("out_a", 64'(out_a), 64'(sb.pop_front()));
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = DW'(d);
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic send_vec(input logic [ZW-1:0] z);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_z     = z;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check_eq("in_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid && sb.size() == 0) ok = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("drain", 64'(ok), 64'd1);
    endtask

    initial begin
        int acc;
        bit hs;
        bit seen;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_a",     64'(out_a),     64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)  cfg_write(k, 4 * k);
        for (int k = 8; k < 16; k++) cfg_write(k, 4 * (k - 16));

        send_vec(16'h2500);
        wait_idle();
        check_eq("z_25_00", 64'(out_a), 64'h0900);
        send_vec(16'h7FF8);
        wait_idle();
        check_eq("z_7f_f8", 64'(out_a), 64'hE3FC);

        out_ready = 1'b0;
        send_vec(16'h2500);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("bp_valid_seen", 64'(seen), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_out_a",     64'(out_a),     64'h0900);
            check_eq("bp_in_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_release_ready", 64'(in_ready),  64'd1);
        check_eq("bp_release_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        send_vec(16'h0025);
        cfg_write(2, 100);
        wait_idle();
        check_eq("cfg_drop_busy", 64'(out_a), 64'h0009);
        cfg_we   = 1'b1;
        cfg_addr = AW'(2);
        cfg_data = DW'(100);
        send_vec(16'h0025);
        wait_idle();
        check_eq("cfg_idle_with_hs", 64'(out_a), 64'h0048);

        send_vec(16'h2500);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready",  64'(in_ready),  64'd1);
        check_eq("arst_busy",      64'(busy),      64'd0);
        sb.delete();
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_vec(16'h7FF8);
        wait_idle();
        check_eq("post_rst_zero", 64'(out_a), 64'h0000);

        for (int k = 0; k < 16; k++) cfg_write(k, int'($urandom_range(0, 255)));
        in_valid = 1'b1;
        in_z     = ZW'($urandom);
        acc      = 0;
        for (int c = 0; c < 20000 && acc < 200; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (hs) begin
                acc++;
                in_z = ZW'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("rand_accepts", 64'(acc), 64'd200);
        wait_idle();
        check_eq("sb_leftover", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
